// File: rtl/snake_step_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : snake_pkg
// Brief  : Shared types and helpers for the snake game step scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package snake_pkg;

    localparam int STEP_CNT_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_STEP = 4'd1,
        ST_WAIT_VB   = 4'd2,
        ST_LATCH     = 4'd3,
        ST_MOVE      = 4'd4,
        ST_CHECK     = 4'd5,
        ST_COMMIT    = 4'd6,
        ST_OVER      = 4'd7,
        ST_FAULT     = 4'd8
    } step_state_e;

    // Base ticks per step for a level; never below 1 so the game always advances.
    function automatic int level_interval(input int base_ticks, input int level_dec, input int level);
        int v;
        v = base_ticks - level * level_dec;
        return (v < 1) ? 1 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_step_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : snake_step_if
// Brief  : Start/done handshake between the step scheduler and the datapath.
// Rev    : 1.0  initial release
// ============================================================================
interface snake_step_if ();

    logic dir_latch;
    logic move_start;
    logic chk_start;
    logic commit;
    logic move_done;
    logic chk_done;
    logic hit;

    modport master (
        output dir_latch,
        output move_start,
        output chk_start,
        output commit,
        input  move_done,
        input  chk_done,
        input  hit
    );

    modport slave (
        input  dir_latch,
        input  move_start,
        input  chk_start,
        input  commit,
        output move_done,
        output chk_done,
        output hit
    );

endinterface
`default_nettype wire

// File: rtl/snake_step_scheduler_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module : tick_prescaler
// Brief  : Divides clk into base ticks; holds while paused or cleared.
// Rev    : 1.0  initial release
// ============================================================================
module tick_prescaler #(
    parameter int PRESCALE = 10_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic pause,
    output logic base_tick
);

    localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PC_W-1:0] c_pc_last = PC_W'(PRESCALE - 1);

    logic [PC_W-1:0] r_pc;
    logic            w_wrap;

    assign w_wrap = (r_pc == c_pc_last);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_pc <= '0;
        end else if (!pause) begin
            r_pc <= w_wrap ? '0 : r_pc + PC_W'(1);
        end
    end

    assign base_tick = w_wrap && !pause && !clear;

endmodule
`default_nettype wire

// File: rtl/snake_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module : snake_step_scheduler
// Brief  : Level-paced, vblank-aligned sequencer for one snake game step.
// Rev    : 1.0  initial release
// ============================================================================
module snake_step_scheduler
    import snake_pkg::*;
#(
    parameter int PRESCALE   = 10_000,
    parameter int BASE_TICKS = 50,
    parameter int LEVEL_DEC  = 5,
    parameter int LEVEL_W    = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  pause,
    input  logic                  restart,
    input  logic [LEVEL_W-1:0]    level,
    input  logic                  vblank,
    snake_step_if.master          dp,
    output logic                  game_over,
    output logic                  fault,
    output logic                  overrun,
    output logic [STEP_CNT_W-1:0] step_count
);

    localparam int TICK_W = 16;
    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] c_wd_last = WD_W'(TIMEOUT - 1);

    step_state_e             r_state;
    logic                    r_dir_latch;
    logic                    r_move_start;
    logic                    r_chk_start;
    logic                    r_commit;
    logic                    r_game_over;
    logic                    r_fault;
    logic                    r_overrun;
    logic                    r_pending;
    logic [STEP_CNT_W-1:0]   r_step_count;
    logic [WD_W-1:0]         r_wd;
    logic [TICK_W-1:0]       r_ticks;
    logic [TICK_W-1:0]       r_interval;

    logic                    w_base_tick;
    logic                    w_cnt_run;
    logic                    w_busy;
    logic                    w_elapsed;
    logic [TICK_W-1:0]       w_next_interval;

    // Cadence only runs while a game is live; IDLE/OVER/FAULT keep it cleared.
    assign w_cnt_run       = !(r_state inside {ST_IDLE, ST_OVER, ST_FAULT});
    assign w_busy          = r_state inside {ST_LATCH, ST_MOVE, ST_CHECK, ST_COMMIT};
    assign w_next_interval = TICK_W'(level_interval(BASE_TICKS, LEVEL_DEC, int'(level)));
    assign w_elapsed       = w_base_tick && ((r_ticks + TICK_W'(1)) == r_interval);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .clear     (!w_cnt_run),
        .pause     (pause),
        .base_tick (w_base_tick)
    );

    always_ff @(posedge clk) begin
        if (reset || !w_cnt_run) begin
            r_ticks    <= '0;
            r_interval <= w_next_interval;
            r_pending  <= 1'b0;
        end else begin
            if (w_elapsed) begin
                r_ticks    <= '0;
                r_interval <= w_next_interval;
            end else if (w_base_tick) begin
                r_ticks <= r_ticks + TICK_W'(1);
            end
            // A new step request outranks the LATCH acknowledge of the old one.
            if (w_elapsed) begin
                r_pending <= 1'b1;
            end else if (r_state == ST_LATCH) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if ((r_state == ST_OVER) && restart) begin
            r_overrun <= 1'b0;
        end else if (w_cnt_run && w_elapsed && (r_pending || w_busy)) begin
            r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_dir_latch  <= 1'b0;
            r_move_start <= 1'b0;
            r_chk_start  <= 1'b0;
            r_commit     <= 1'b0;
            r_game_over  <= 1'b0;
            r_fault      <= 1'b0;
            r_step_count <= '0;
            r_wd         <= '0;
        end else begin
            r_dir_latch  <= 1'b0;
            r_move_start <= 1'b0;
            r_chk_start  <= 1'b0;
            r_commit     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (run) r_state <= ST_WAIT_STEP;
                end
                ST_WAIT_STEP: begin
                    if (!run)           r_state <= ST_IDLE;
                    else if (r_pending) r_state <= ST_WAIT_VB;
                end
                ST_WAIT_VB: begin
                    if (!run) begin
                        r_state <= ST_IDLE;
                    end else if (vblank) begin
                        r_state     <= ST_LATCH;
                        r_dir_latch <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    r_state      <= ST_MOVE;
                    r_move_start <= 1'b1;
                    r_wd         <= '0;
                end
                ST_MOVE: begin
                    if (dp.move_done) begin
                        r_state     <= ST_CHECK;
                        r_chk_start <= 1'b1;
                        r_wd        <= '0;
                    end else if (r_wd == c_wd_last) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (dp.chk_done) begin
                        if (dp.hit) begin
                            r_state     <= ST_OVER;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state      <= ST_COMMIT;
                            r_commit     <= 1'b1;
                            r_step_count <= r_step_count + STEP_CNT_W'(1);
                        end
                    end else if (r_wd == c_wd_last) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                ST_COMMIT: begin
                    r_state <= run ? ST_WAIT_STEP : ST_IDLE;
                end
                ST_OVER: begin
                    if (restart) begin
                        r_state      <= ST_IDLE;
                        r_game_over  <= 1'b0;
                        r_step_count <= '0;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dp.dir_latch  = r_dir_latch;
    assign dp.move_start = r_move_start;
    assign dp.chk_start  = r_chk_start;
    assign dp.commit     = r_commit;
    assign game_over     = r_game_over;
    assign fault         = r_fault;
    assign overrun       = r_overrun;
    assign step_count    = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_snake_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_snake_step_scheduler
// Brief  : Directed bench for snake_step_scheduler with a small datapath responder.
// Rev    : 1.0  initial release
// ============================================================================
module tb_snake_step_scheduler;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        run     = 1'b0;
    logic        pause   = 1'b0;
    logic        restart = 1'b0;
    logic        vblank  = 1'b0;
    logic [2:0]  level   = 3'd0;
    logic        game_over;
    logic        fault;
    logic        overrun;
    logic [15:0] step_count;

    logic resp_move = 1'b1;
    logic resp_chk  = 1'b1;
    logic hit_val   = 1'b0;
    logic mv_req    = 1'b0;
    logic ck_req    = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    int first_dl, first_ms, first_cs, first_ov, first_go, first_ft, n_commit;
    int commit_k [4];
    int commit_n [4];
    logic acc;

    snake_step_if bus ();

    snake_step_scheduler #(
        .PRESCALE   (4),
        .BASE_TICKS (3),
        .LEVEL_DEC  (5),
        .LEVEL_W    (3),
        .TIMEOUT    (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .pause      (pause),
        .restart    (restart),
        .level      (level),
        .vblank     (vblank),
        .dp         (bus.master),
        .game_over  (game_over),
        .fault      (fault),
        .overrun    (overrun),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Datapath stand-in: answers each start one cycle later when enabled.
    initial begin
        bus.move_done = 1'b0;
        bus.chk_done  = 1'b0;
        bus.hit       = 1'b0;
        forever begin
            @(negedge clk);
            bus.move_done = resp_move && mv_req;
            bus.chk_done  = resp_chk && ck_req;
            bus.hit       = hit_val && ck_req;
            mv_req        = bus.move_start;
            ck_req        = bus.chk_start;
        end
    end

    // Raises run at k=0 and logs first-event cycles relative to it.
    task automatic observe(input int len, input int p_on, input int p_off, input int vb_at);
        first_dl = -1; first_ms = -1; first_cs = -1;
        first_ov = -1; first_go = -1; first_ft = -1;
        n_commit = 0;
        for (int i = 0; i < 4; i++) begin
            commit_k[i] = -1;
            commit_n[i] = -1;
        end
        run = 1'b1;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (bus.dir_latch  && first_dl < 0) first_dl = k;
            if (bus.move_start && first_ms < 0) first_ms = k;
            if (bus.chk_start  && first_cs < 0) first_cs = k;
            if (overrun        && first_ov < 0) first_ov = k;
            if (game_over      && first_go < 0) first_go = k;
            if (fault          && first_ft < 0) first_ft = k;
            if (bus.commit) begin
                if (n_commit < 4) begin
                    commit_k[n_commit] = k;
                    commit_n[n_commit] = int'(step_count);
                end
                n_commit++;
            end
            if (k == p_on)  pause  = 1'b1;
            if (k == p_off) pause  = 1'b0;
            if (k == vb_at) vblank = 1'b1;
        end
    endtask

    task automatic go_idle();
        run = 1'b0;
        tick(10);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL global_timeout: got no finish, expected finish before 1ms");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        // Reset values and a quiet idle period.
        tick(4);
        check_eq("rst_dir_latch",  int'(bus.dir_latch),  0);
        check_eq("rst_move_start", int'(bus.move_start), 0);
        check_eq("rst_chk_start",  int'(bus.chk_start),  0);
        check_eq("rst_commit",     int'(bus.commit),     0);
        check_eq("rst_game_over",  int'(game_over),      0);
        check_eq("rst_fault",      int'(fault),          0);
        check_eq("rst_overrun",    int'(overrun),        0);
        check_eq("rst_step_count", int'(step_count),     0);
        reset = 1'b0;
        acc   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            acc = acc | bus.dir_latch | bus.move_start | bus.chk_start | bus.commit
                      | game_over | fault | overrun | (|step_count);
        end
        check_eq("idle_quiet", int'(acc), 0);

        // Cadence: interval 3 ticks of 4 cycles.
        vblank = 1'b1;
        observe(45, -1, -1, -1);
        check_eq("cad_dir_latch_k",  first_dl, 15);
        check_eq("cad_move_start_k", first_ms, 16);
        check_eq("cad_chk_start_k",  first_cs, 18);
        check_eq("cad_n_commit",     n_commit, 3);
        check_eq("cad_commit0_k",    commit_k[0], 20);
        check_eq("cad_commit1_k",    commit_k[1], 32);
        check_eq("cad_commit2_k",    commit_k[2], 44);
        check_eq("cad_count0",       commit_n[0], 1);
        check_eq("cad_count1",       commit_n[1], 2);
        check_eq("cad_count2",       commit_n[2], 3);
        check_eq("cad_no_overrun",   first_ov, -1);
        go_idle();

        // Pause for 50 cycles pushes the first commit from 20 to 70.
        observe(72, 2, 52, -1);
        check_eq("pause_commit_k",   commit_k[0], 70);
        check_eq("pause_count",      commit_n[0], 4);
        check_eq("pause_n_commit",   n_commit, 1);
        check_eq("pause_no_overrun", first_ov, -1);
        go_idle();

        // Level 7 saturates the interval to a single base tick.
        level = 3'd7;
        tick(2);
        observe(21, -1, -1, -1);
        check_eq("sat_commit0_k", commit_k[0], 12);
        check_eq("sat_commit1_k", commit_k[1], 20);
        check_eq("sat_count0",    commit_n[0], 5);
        check_eq("sat_count1",    commit_n[1], 6);
        check_eq("sat_overrun_k", first_ov, 9);
        go_idle();
        level = 3'd0;
        tick(2);

        // Collision then restart.
        hit_val = 1'b1;
        observe(25, -1, -1, -1);
        check_eq("hit_game_over_k",  first_go, 20);
        check_eq("hit_no_commit",    n_commit, 0);
        check_eq("hit_step_count",   int'(step_count), 6);
        restart = 1'b1;
        run     = 1'b0;
        tick(1);
        restart = 1'b0;
        hit_val = 1'b0;
        check_eq("rs_game_over",  int'(game_over),  0);
        check_eq("rs_step_count", int'(step_count), 0);
        check_eq("rs_overrun",    int'(overrun),    0);
        tick(2);

        // vblank held low for 30 cycles while a step is pending.
        vblank = 1'b0;
        observe(50, -1, -1, 43);
        check_eq("vb_dir_latch_k",  first_dl, 44);
        check_eq("vb_move_start_k", first_ms, 45);
        check_eq("vb_overrun_k",    first_ov, 25);
        check_eq("vb_commit_k",     commit_k[0], 49);
        check_eq("vb_count",        commit_n[0], 1);
        go_idle();
        vblank = 1'b1;

        // Watchdog: move_done withheld.
        resp_move = 1'b0;
        observe(33, -1, -1, -1);
        check_eq("wd_move_start_k", first_ms, 16);
        check_eq("wd_fault_k",      first_ft, 32);
        check_eq("wd_no_chk_start", first_cs, -1);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        resp_move = 1'b1;
        observe(30, -1, -1, -1);
        check_eq("wd_restart_ignored", int'(fault), 1);
        check_eq("wd_no_dir_latch",    first_dl, -1);
        check_eq("wd_no_commit",       n_commit, 0);
        check_eq("wd_step_count",      int'(step_count), 1);
        reset = 1'b1;
        run   = 1'b0;
        tick(1);
        reset = 1'b0;
        check_eq("wd_reset_fault",      int'(fault),      0);
        check_eq("wd_reset_overrun",    int'(overrun),    0);
        check_eq("wd_reset_step_count", int'(step_count), 0);

        // Reset in the middle of a sequence.
        tick(2);
        observe(16, -1, -1, -1);
        check_eq("mid_move_start_k", first_ms, 16);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        run   = 1'b0;
        acc   = bus.dir_latch | bus.move_start | bus.chk_start | bus.commit;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            acc = acc | bus.dir_latch | bus.move_start | bus.chk_start | bus.commit;
        end
        check_eq("mid_reset_quiet",      int'(acc),        0);
        check_eq("mid_reset_step_count", int'(step_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
